// File: rtl/dmem_arbiter.sv
// dmem_arbiter: single-port data memory arbiter between the CPU MEM stage and
// a debug requester. Zero-cycle grant, combinational mem_* from the winner,
// registered return-path FSM steering mem_rdata back to the load's owner.
// Optional macro DMEM_ARB_FAIRNESS_EN enables the debug starvation guard;
// without it the CPU always wins contested cycles.
module dmem_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned ADDR_W       = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [31:0]       cpu_wdata,
   output logic              cpu_stall,
   output logic [31:0]       cpu_rdata,
   output logic              cpu_rvalid,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [31:0]       dbg_wdata,
   output logic              dbg_gnt,
   output logic [31:0]       dbg_rdata,
   output logic              dbg_rvalid,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RD_CPU = 2'd1,
      RD_DBG = 2'd2
   } state_t;

   localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

   state_t state;
   state_t state_nxt;
   logic   cpu_win;
   logic   dbg_win;
   logic   starved;

`ifdef DMEM_ARB_FAIRNESS_EN
   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] starve_cnt;
   logic [CNT_W-1:0] starve_cnt_nxt;

   assign starved = (starve_cnt == LIMIT);

   // Count contested cycles won by the CPU; any other cycle restarts the count
   always_comb begin
      starve_cnt_nxt = '0;
      if (cpu_req && dbg_req && cpu_win) begin
         starve_cnt_nxt = starve_cnt + CNT_W'(1);
      end
   end

   // Starvation counter register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starve_cnt <= '0;
      end else begin
         starve_cnt <= starve_cnt_nxt;
      end
   end
`else
   localparam int unsigned unused_starve_limit = STARVE_LIMIT;

   assign starved = 1'b0;
`endif

   // Return FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Arbitration, memory drive, next-state and return-path steering
   always_comb begin
      cpu_win    = 1'b0;
      dbg_win    = 1'b0;
      state_nxt  = IDLE;
      mem_en     = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      cpu_stall  = 1'b0;
      dbg_gnt    = 1'b0;
      cpu_rvalid = 1'b0;
      cpu_rdata  = '0;
      dbg_rvalid = 1'b0;
      dbg_rdata  = '0;

      // Everything combinational is held quiet while reset is asserted
      if (rst) begin
         if (cpu_req && dbg_req) begin
            if (starved) begin
               dbg_win = 1'b1;
            end else begin
               cpu_win = 1'b1;
            end
         end else if (cpu_req) begin
            cpu_win = 1'b1;
         end else if (dbg_req) begin
            dbg_win = 1'b1;
         end
      end

      if (cpu_win) begin
         mem_en    = 1'b1;
         mem_we    = cpu_we;
         mem_addr  = cpu_addr & WORD_MASK;
         mem_wdata = cpu_we ? cpu_wdata : 32'd0;
         if (!cpu_we) begin
            state_nxt = RD_CPU;
         end
      end else if (dbg_win) begin
         mem_en    = 1'b1;
         mem_we    = dbg_we;
         mem_addr  = dbg_addr & WORD_MASK;
         mem_wdata = dbg_we ? dbg_wdata : 32'd0;
         if (!dbg_we) begin
            state_nxt = RD_DBG;
         end
      end

      cpu_stall = rst && cpu_req && !cpu_win;
      dbg_gnt   = dbg_win;

      case (state)
         RD_CPU: begin
            cpu_rvalid = 1'b1;
            cpu_rdata  = mem_rdata;
         end
         RD_DBG: begin
            dbg_rvalid = 1'b1;
            dbg_rdata  = mem_rdata;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed, table-driven bench for dmem_arbiter (default parameters).
module tb_dmem_arbiter;

   localparam int unsigned AW = 32;
   localparam int unsigned NV = 17;

   logic          clk;
   logic          rst;
   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [31:0]   cpu_wdata;
   logic          cpu_stall;
   logic [31:0]   cpu_rdata;
   logic          cpu_rvalid;
   logic          dbg_req;
   logic          dbg_we;
   logic [AW-1:0] dbg_addr;
   logic [31:0]   dbg_wdata;
   logic          dbg_gnt;
   logic [31:0]   dbg_rdata;
   logic          dbg_rvalid;
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata;

   dmem_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_stall  (cpu_stall),
      .cpu_rdata  (cpu_rdata),
      .cpu_rvalid (cpu_rvalid),
      .dbg_req    (dbg_req),
      .dbg_we     (dbg_we),
      .dbg_addr   (dbg_addr),
      .dbg_wdata  (dbg_wdata),
      .dbg_gnt    (dbg_gnt),
      .dbg_rdata  (dbg_rdata),
      .dbg_rvalid (dbg_rvalid),
      .mem_en     (mem_en),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        cr;
      logic        cw;
      logic [31:0] ca;
      logic [31:0] cd;
      logic        dr;
      logic        dw;
      logic [31:0] da;
      logic [31:0] dd;
      logic [31:0] mrd;
      logic        e_en;
      logic        e_we;
      logic [31:0] e_addr;
      logic [31:0] e_wdata;
      logic        e_stall;
      logic        e_gnt;
      logic        e_crv;
      logic [31:0] e_crd;
      logic        e_drv;
      logic [31:0] e_drd;
   } vec_t;

   vec_t vecs [NV];
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic logic [255:0] outs();
      return 256'({mem_en, mem_we, mem_addr, mem_wdata, cpu_stall, dbg_gnt,
                   cpu_rvalid, cpu_rdata, dbg_rvalid, dbg_rdata});
   endfunction

   function automatic logic [255:0] exp_of(input vec_t v);
      return 256'({v.e_en, v.e_we, v.e_addr, v.e_wdata, v.e_stall, v.e_gnt,
                   v.e_crv, v.e_crd, v.e_drv, v.e_drd});
   endfunction

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      cpu_req   = v.cr;
      cpu_we    = v.cw;
      cpu_addr  = v.ca;
      cpu_wdata = v.cd;
      dbg_req   = v.dr;
      dbg_we    = v.dw;
      dbg_addr  = v.da;
      dbg_wdata = v.dd;
      mem_rdata = v.mrd;
   endtask

   // One cycle: drive after the rising edge, compare at the falling edge
   task automatic apply(input string name, input vec_t v);
      @(posedge clk);
      #1;
      drive(v);
      @(negedge clk);
      check(name, outs(), exp_of(v));
   endtask

   initial begin
      logic fair;
      logic cw;
      logic dw;
      logic prev_cw;
      logic prev_dw;
      vec_t z;
      vec_t v;

`ifdef DMEM_ARB_FAIRNESS_EN
      fair = 1'b1;
`else
      fair = 1'b0;
`endif

      //         cr cw ca     cd     dr dw da     dd            mrd        en we addr   wdata         st gn crv crd     drv drd
      vecs[0]  = '{0, 0, 0,     0,     0, 0, 0,     0,            0,         0, 0, 0,     0,            0, 0, 0, 0,      0, 0};
      vecs[1]  = '{1, 0, 'h50,  0,     0, 0, 0,     0,            0,         1, 0, 'h50,  0,            0, 0, 0, 0,      0, 0};
      vecs[2]  = '{0, 0, 0,     0,     0, 0, 0,     0,            'hB,       0, 0, 0,     0,            0, 0, 1, 'hB,    0, 0};
      vecs[3]  = '{1, 1, 'h54,  'h11,  0, 0, 0,     0,            0,         1, 1, 'h54,  'h11,         0, 0, 0, 0,      0, 0};
      vecs[4]  = '{0, 0, 0,     0,     0, 0, 0,     0,            'hDEAD,    0, 0, 0,     0,            0, 0, 0, 0,      0, 0};
      vecs[5]  = '{1, 0, 'h53,  0,     0, 0, 0,     0,            0,         1, 0, 'h50,  0,            0, 0, 0, 0,      0, 0};
      vecs[6]  = '{0, 0, 0,     0,     1, 0, 'h54,  0,            'hA1,      1, 0, 'h54,  0,            0, 1, 1, 'hA1,   0, 0};
      vecs[7]  = '{1, 0, 'h50,  0,     0, 0, 0,     0,            'hB2,      1, 0, 'h50,  0,            0, 0, 0, 0,      1, 'hB2};
      vecs[8]  = '{0, 0, 0,     0,     1, 0, 'h54,  0,            'hC3,      1, 0, 'h54,  0,            0, 1, 1, 'hC3,   0, 0};
      vecs[9]  = '{0, 0, 0,     0,     0, 0, 0,     0,            'hD4,      0, 0, 0,     0,            0, 0, 0, 0,      1, 'hD4};
      vecs[10] = '{0, 0, 0,     0,     1, 1, 'h60,  'h77,         0,         1, 1, 'h60,  'h77,         0, 1, 0, 0,      0, 0};
      vecs[11] = '{1, 0, 'h60,  0,     0, 0, 0,     0,            0,         1, 0, 'h60,  0,            0, 0, 0, 0,      0, 0};
      vecs[12] = '{0, 0, 0,     0,     0, 0, 0,     0,            'h77,      0, 0, 0,     0,            0, 0, 1, 'h77,   0, 0};
      vecs[13] = '{1, 0, 'h10,  'h5,   1, 0, 'h20,  'h6,          0,         1, 0, 'h10,  0,            0, 0, 0, 0,      0, 0};
      vecs[14] = '{0, 0, 0,     0,     0, 0, 0,     0,            'h99,      0, 0, 0,     0,            0, 0, 1, 'h99,   0, 0};
      vecs[15] = '{0, 1, 'h40,  'h1,   1, 1, 'h7C,  'hFFFFFFFF,   0,         1, 1, 'h7C,  'hFFFFFFFF,   0, 1, 0, 0,      0, 0};
      vecs[16] = '{0, 0, 0,     0,     0, 0, 0,     0,            0,         0, 0, 0,     0,            0, 0, 0, 0,      0, 0};
      z = vecs[0];

      // Reset: requests present, yet everything must read zero
      rst = 1'b0;
      drive(z);
      cpu_req  = 1'b1;
      cpu_addr = 32'h50;
      dbg_req  = 1'b1;
      #3;
      check("reset_outputs", outs(), 256'd0);
      @(posedge clk);
      #1;
      drive(z);
      rst = 1'b1;

      for (int i = 0; i < int'(NV); i++) begin
         apply($sformatf("vec%0d", i), vecs[i]);
      end

      // Ten contested cycles, CPU load 0x100 vs debug load 0x200
      prev_cw = 1'b0;
      prev_dw = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         drive(z);
         cpu_req  = 1'b1;
         cpu_addr = 32'h100;
         dbg_req  = 1'b1;
         dbg_addr = 32'h200;
         mem_rdata = 32'h1000 + 32'(i);
         @(negedge clk);
         dw = fair && (i == 4 || i == 9);
         cw = !dw;
         check($sformatf("contend%0d", i),
               256'({cpu_stall, dbg_gnt, mem_addr, cpu_rvalid, cpu_rdata, dbg_rvalid, dbg_rdata}),
               256'({dw, dw, (dw ? 32'h200 : 32'h100),
                     prev_cw, (prev_cw ? mem_rdata : 32'd0),
                     prev_dw, (prev_dw ? mem_rdata : 32'd0)}));
         prev_cw = cw;
         prev_dw = dw;
      end
      v = z;
      v.mrd   = 32'h2222;
      v.e_crv = prev_cw;
      v.e_crd = prev_cw ? 32'h2222 : 32'd0;
      v.e_drv = prev_dw;
      v.e_drd = prev_dw ? 32'h2222 : 32'd0;
      apply("contend_tail", v);

      // Reset lands between a debug load grant and its return
      v = z;
      v.dr = 1'b1; v.da = 32'h50;
      v.e_en = 1'b1; v.e_addr = 32'h50; v.e_gnt = 1'b1;
      apply("rst_mid_grant", v);
      #2;
      rst = 1'b0;
      #1;
      check("rst_mid_async", outs(), 256'd0);
      @(posedge clk);
      #2;
      drive(z);
      mem_rdata = 32'h5A;
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_no_rvalid", outs(), 256'd0);

      // First cycle after reset arbitrates fresh
      v = vecs[1];
      apply("post_rst_grant", v);
      v = vecs[2];
      apply("post_rst_return", v);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive contested cycles CPU may win before debug is forced through (range 1-15).
REQ-002 Parameter ADDR_W, default 32: byte-address width on all ports.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset; rst=0 resets all state immediately, independent of clk.
REQ-005 cpu_req  input  1  MEM-stage access request (lw/sw).
REQ-006 cpu_we  input  1  1 = store, 0 = load; qualified by cpu_req.
REQ-007 cpu_addr  input  ADDR_W  byte address; bits [1:0] ignored.
REQ-008 cpu_wdata  input  32  store data.
REQ-009 cpu_stall  output  1  CPU request pending but not granted this cycle; pipeline holds MEM stage.
REQ-010 cpu_rdata  output  32  load data, valid when cpu_rvalid=1.
REQ-011 cpu_rvalid  output  1  one-cycle pulse, load data returned.
REQ-012 dbg_req, dbg_we, dbg_addr, dbg_wdata  input  1/1/ADDR_W/32  debug/bench-side requester, same meaning as CPU fields.
REQ-013 dbg_gnt  output  1  debug request accepted this cycle.
REQ-014 dbg_rdata  output  32  debug load data, valid when dbg_rvalid=1.
REQ-015 dbg_rvalid  output  1  one-cycle pulse, debug load data returned.
REQ-016 mem_en, mem_we  output  1/1  single-port data memory enable and write strobe.
REQ-017 mem_addr, mem_wdata  output  ADDR_W/32  memory address (byte address, word-aligned, [1:0]=0) and write data.
REQ-018 mem_rdata  input  32  memory read data, valid the cycle after mem_en=1 with mem_we=0.

Function
REQ-019 At most one memory access shall issue per cycle; mem_* shall be driven combinationally from the current cycle's winner.
REQ-020 Uncontested request shall be granted in the same cycle (zero-cycle arbitration latency).
REQ-021 Contested cycle (both req=1): CPU shall win unless starve_cnt == STARVE_LIMIT, in which case debug shall win.
REQ-022 starve_cnt (4-bit) shall increment on each contested cycle CPU wins, clear when debug is granted or dbg_req=0, and never exceed STARVE_LIMIT.
REQ-023 cpu_stall shall equal cpu_req AND NOT CPU-granted; dbg_gnt shall equal debug-granted; a stalled requester keeps its request fields stable.
REQ-024 Return FSM states IDLE, RD_CPU, RD_DBG: next state RD_CPU after a CPU load grant, RD_DBG after a debug load grant, IDLE otherwise (including writes and no grant).
REQ-025 In RD_CPU: cpu_rvalid=1, cpu_rdata=mem_rdata; in RD_DBG: dbg_rvalid=1, dbg_rdata=mem_rdata; rdata outputs shall be 0 when the matching rvalid=0.
REQ-026 Back-to-back loads from either requester shall sustain one access per cycle with rvalid on consecutive cycles.
REQ-027 Stores shall produce no rvalid; mem_we=1 only in the grant cycle of a store.
REQ-028 Same-address conflict (debug store and CPU load same word, consecutive cycles) shall resolve in grant order; no reordering.

Reset
REQ-029 While rst=0: FSM=IDLE, starve_cnt=0, mem_en=0, mem_we=0, cpu_stall=0, dbg_gnt=0, both rvalid=0, both rdata=0, mem_addr=0, mem_wdata=0.
REQ-030 Reset asserted between a load grant and its return shall suppress that rvalid; the first cycle after rst rises arbitrates fresh.

Configuration
REQ-031 Macro DMEM_ARB_FAIRNESS_EN: defined, starvation guard per REQ-021/022 active; undefined, starve_cnt is absent and CPU always wins contested cycles (debug waits indefinitely while cpu_req=1).

Verification
REQ-032 CPU load addr 0x50, mem_rdata=0x0000_000B next cycle -> mem_en=1, mem_addr=0x50, cpu_stall=0; next cycle cpu_rvalid=1, cpu_rdata=0x0000_000B.
REQ-033 CPU store 0x54 data 0x0000_0011 -> mem_we=1, mem_wdata=0x11 in grant cycle; no rvalid on either port.
REQ-034 cpu_req and dbg_req held 1 for 10 cycles, STARVE_LIMIT=4, macro defined -> CPU granted cycles 0-3, debug cycle 4, CPU cycles 5-8, debug cycle 9; cpu_stall=1 exactly in cycles 4 and 9.
REQ-035 Same stimulus, macro undefined -> CPU granted all 10 cycles, dbg_gnt=0 throughout.
REQ-036 Debug load 0x50 granted, rst pulled low for 3 ns before next edge -> dbg_rvalid stays 0, all outputs at reset values, FSM=IDLE after release.
REQ-037 Alternating CPU load 0x50 / debug load 0x54 every cycle, no contention -> rvalid alternates cpu/dbg each cycle with matching mem_rdata, no stalls.
